wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
Write-back end of the pipeline: consumes the registered MEM/WB stage outputs, forms the final write-back value, and commits it to a 32x32 general register file. It also serves the two decode-stage read ports with same-cycle write-through bypass, and keeps a retired-write counter for debug. It sits between the MEM/WB pipeline register and the ID stage.

Parameters:
DATA_W, 32, register and datapath width
ADDR_W, 5, register address width (2**ADDR_W registers)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
RegWriteW  input  1  write-back enable from MEM/WB
MemtoRegW  input  1  1 = select load data, 0 = select ALU result
alu_outW  input  32  ALU result; low 2 bits are the byte offset for loads
r3_addrW  input  5  destination register
opW  input  6  opcode of the instruction in WB
doutbW  input  32  raw data-memory word
r1_addr  input  5  read port 1 address (ID stage)
r2_addr  input  5  read port 2 address (ID stage)
r1_dout  output  32  read port 1 data
r2_dout  output  32  read port 2 data
wb_dataW  output  32  final write-back value, for forwarding
wb_count  output  32  number of cycles in which RegWriteW was 1

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- On reset, all 32 registers are cleared to 0 and wb_count is cleared to 0. Combinational outputs follow their inputs even during reset.
- Load extraction is little-endian. off = alu_outW[1:0].
  - opW 6'h23 (lw): doutbW.
  - 6'h20 (lb): byte[off], sign-extended.
  - 6'h24 (lbu): byte[off], zero-extended.
  - 6'h21 (lh): half[alu_outW[1]], sign-extended; alu_outW[0] is ignored.
  - 6'h25 (lhu): same half, zero-extended.
  - Any other opW with MemtoRegW=1: doutbW unmodified.
  - byte0 = doutbW[7:0]; half0 = doutbW[15:0].
- wb_dataW = MemtoRegW ? extracted load value : alu_outW. This path is combinational.
- Register write: at the rising edge where RegWriteW=1 and r3_addrW!=0, regs[r3_addrW] <= wb_dataW.
  - Writes to r0 are discarded.
  - Register 0 always reads 0.
- Reads are combinational, with priority:
  1. addr==0 gives 0.
  2. If RegWriteW=1 and addr==r3_addrW, the output is wb_dataW (write-through bypass, same cycle).
  3. Otherwise the output is regs[addr].
- Both read ports are independent and may read the same address.
- wb_count increments by 1 at every rising edge with RegWriteW=1, including writes to r0. It wraps from 32'hFFFFFFFF to 0.
- Total write-back latency: the value is visible on the read ports in the same cycle via bypass, and from storage starting the next cycle.
- Reset mid-operation: a write pending at the same edge as reset assertion is lost, and the register reads 0 after reset.
- X on RegWriteW is not tolerated. The bench asserts RegWriteW is never X outside reset.

Test Plan:
- Reset: assert rst_n=0 mid-run after writing r5=32'h1234 -> r1_addr=5 gives 0 immediately and after release; wb_count=0.
- ALU write + bypass: RegWriteW=1, MemtoRegW=0, alu_outW=32'hDEADBEEF, r3_addrW=7, r1_addr=7 -> r1_dout=32'hDEADBEEF in the same cycle. Next cycle with RegWriteW=0, r1_dout is still 32'hDEADBEEF.
- Loads: doutbW=32'h80FF7F01, MemtoRegW=1.
  - lb, off=3 -> 32'hFFFFFF80.
  - lbu, off=3 -> 32'h00000080.
  - lh, alu_outW[1]=1 -> 32'hFFFF80FF.
  - lhu, off=0 -> 32'h00007F01.
  - lw -> 32'h80FF7F01.
- r0 protection: write 32'hFFFFFFFF to r3_addrW=0 -> r1_dout and r2_dout for addr 0 read 0; wb_count increments by 1.
- Dual port: r10=32'hA, r11=32'hB; r1_addr=10, r2_addr=11 -> 32'hA and 32'hB. Both ports at 10 -> both read 32'hA.
- Counter wrap: force 2**32-1 writes or preload via hierarchical deposit to 32'hFFFFFFFF, then one write -> wb_count=0.

Source files
------------

// File: rtl/wb_regfile.sv
// Write-back stage: forms the final load/ALU value, commits it to the 32-entry
// register file, serves two bypassed read ports and counts retired writes.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWriteW,
  input  logic              MemtoRegW,
  input  logic [DATA_W-1:0] alu_outW,
  input  logic [ADDR_W-1:0] r3_addrW,
  input  logic [5:0]        opW,
  input  logic [DATA_W-1:0] doutbW,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [ADDR_W-1:0] r2_addr,
  output logic [DATA_W-1:0] r1_dout,
  output logic [DATA_W-1:0] r2_dout,
  output logic [DATA_W-1:0] wb_dataW,
  output logic [DATA_W-1:0] wb_count
);

  localparam int NREGS = 2 ** ADDR_W;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;

  logic [DATA_W-1:0] regFile [NREGS];
  logic [DATA_W-1:0] wbCount;
  logic [DATA_W-1:0] loadVal;
  logic [7:0]        byteSel;
  logic [15:0]       halfSel;

  // Little-endian lane select; halfword ignores alu_outW[0].
  always_comb begin
    byteSel = doutbW[7:0];
    case (alu_outW[1:0])
      2'd0: byteSel = doutbW[7:0];
      2'd1: byteSel = doutbW[15:8];
      2'd2: byteSel = doutbW[23:16];
      2'd3: byteSel = doutbW[31:24];
      default: byteSel = doutbW[7:0];
    endcase
    halfSel = alu_outW[1] ? doutbW[31:16] : doutbW[15:0];
  end

  always_comb begin
    loadVal = doutbW;
    case (opW)
      OP_LB:  loadVal = {{(DATA_W-8){byteSel[7]}}, byteSel};
      OP_LBU: loadVal = {{(DATA_W-8){1'b0}}, byteSel};
      OP_LH:  loadVal = {{(DATA_W-16){halfSel[15]}}, halfSel};
      OP_LHU: loadVal = {{(DATA_W-16){1'b0}}, halfSel};
      OP_LW:  loadVal = doutbW;
      default: loadVal = doutbW;
    endcase
  end

  assign wb_dataW = MemtoRegW ? loadVal : alu_outW;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regFile[i] <= '0;
      end
    end else if (RegWriteW && (r3_addrW != '0)) begin
      regFile[r3_addrW] <= wb_dataW;
    end
  end

  // Counts every enabled write-back, including discarded writes to r0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbCount <= '0;
    end else if (RegWriteW) begin
      wbCount <= wbCount + 1'b1;
    end
  end

  assign wb_count = wbCount;

  // r0 is hard zero; an in-flight write to the same address bypasses storage.
  always_comb begin
    r1_dout = regFile[r1_addr];
    if (r1_addr == '0) begin
      r1_dout = '0;
    end else if (RegWriteW && (r1_addr == r3_addrW)) begin
      r1_dout = wb_dataW;
    end
  end

  always_comb begin
    r2_dout = regFile[r2_addr];
    if (r2_addr == '0) begin
      r2_dout = '0;
    end else if (RegWriteW && (r2_addr == r3_addrW)) begin
      r2_dout = wb_dataW;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, ALU write-back with bypass, load
// extraction, r0 protection, dual-port reads and counter wrap.
module tb_wb_regfile;

  logic        clk;
  logic        rst_n;
  logic        RegWriteW;
  logic        MemtoRegW;
  logic [31:0] alu_outW;
  logic [4:0]  r3_addrW;
  logic [5:0]  opW;
  logic [31:0] doutbW;
  logic [4:0]  r1_addr;
  logic [4:0]  r2_addr;
  logic [31:0] r1_dout;
  logic [31:0] r2_dout;
  logic [31:0] wb_dataW;
  logic [31:0] wb_count;

  int          checks;
  int          errors;
  logic [31:0] model_count;
  logic [31:0] exp_q[$];

  wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .RegWriteW (RegWriteW),
    .MemtoRegW (MemtoRegW),
    .alu_outW  (alu_outW),
    .r3_addrW  (r3_addrW),
    .opW       (opW),
    .doutbW    (doutbW),
    .r1_addr   (r1_addr),
    .r2_addr   (r2_addr),
    .r1_dout   (r1_dout),
    .r2_dout   (r2_dout),
    .wb_dataW  (wb_dataW),
    .wb_count  (wb_count)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!$isunknown(RegWriteW)) else $error("RegWriteW is X outside reset");
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_sb(input string tag, input logic [31:0] got);
    logic [31:0] exp;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got %h", tag, got);
    end else begin
      exp = exp_q.pop_front();
      check_val(tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic drive_wb(input logic we, input logic m2r, input logic [31:0] alu,
                          input logic [4:0] rd, input logic [5:0] op, input logic [31:0] dout);
    RegWriteW = we;
    MemtoRegW = m2r;
    alu_outW  = alu;
    r3_addrW  = rd;
    opW       = op;
    doutbW    = dout;
  endtask

  task automatic set_reads(input logic [4:0] a1, input logic [4:0] a2);
    r1_addr = a1;
    r2_addr = a2;
  endtask

  task automatic idle();
    drive_wb(1'b0, 1'b0, 32'h0, 5'd0, 6'h0, 32'h0);
  endtask

  // One full cycle: edge, then back to the falling edge for the next drive.
  task automatic tick();
    @(posedge clk);
    if (rst_n && RegWriteW) model_count++;
    @(negedge clk);
  endtask

  task automatic write_reg(input logic [4:0] rd, input logic [31:0] val);
    drive_wb(1'b1, 1'b0, val, rd, 6'h0, 32'h0);
    tick();
    idle();
  endtask

  localparam int NLOADS = 11;
  logic [5:0]  ld_op  [NLOADS] = '{6'h20, 6'h24, 6'h21, 6'h25, 6'h23, 6'h20, 6'h20,
                                   6'h20, 6'h21, 6'h00, 6'h21};
  logic [31:0] ld_alu [NLOADS] = '{32'h3, 32'h3, 32'h2, 32'h0, 32'h1, 32'h0, 32'h1,
                                   32'h2, 32'h3, 32'h2, 32'h0};
  logic [31:0] ld_exp [NLOADS] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01,
                                   32'h80FF7F01, 32'h00000001, 32'h0000007F, 32'hFFFFFFFF,
                                   32'hFFFF80FF, 32'h80FF7F01, 32'h00007F01};

  initial begin
    checks      = 0;
    errors      = 0;
    model_count = 32'h0;
    rst_n       = 1'b0;
    idle();
    set_reads(5'd0, 5'd0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    set_reads(5'd5, 5'd31);
    #1;
    check_val("reset_r5", r1_dout, 32'h0);
    check_val("reset_r31", r2_dout, 32'h0);
    check_val("reset_count", wb_count, 32'h0);
    @(negedge clk);

    // ALU write with same-cycle bypass, then storage read
    drive_wb(1'b1, 1'b0, 32'hDEADBEEF, 5'd7, 6'h0, 32'h0);
    set_reads(5'd7, 5'd3);
    #1;
    check_val("alu_wbdata", wb_dataW, 32'hDEADBEEF);
    check_val("alu_bypass_r1", r1_dout, 32'hDEADBEEF);
    check_val("alu_other_r2", r2_dout, 32'h0);
    tick();
    idle();
    #1;
    check_val("alu_stored_r1", r1_dout, 32'hDEADBEEF);
    check_val("alu_count", wb_count, model_count);
    @(negedge clk);

    // Load extraction, no commit
    for (int i = 0; i < NLOADS; i++) begin
      exp_q.push_back(ld_exp[i]);
    end
    for (int i = 0; i < NLOADS; i++) begin
      drive_wb(1'b0, 1'b1, ld_alu[i], 5'd9, ld_op[i], 32'h80FF7F01);
      #1;
      check_sb($sformatf("load_%0d_op%h_off%0d", i, ld_op[i], ld_alu[i][1:0]), wb_dataW);
    end

    // Committed lbu into r12
    drive_wb(1'b1, 1'b1, 32'h2, 5'd12, 6'h24, 32'h80FF7F01);
    set_reads(5'd12, 5'd9);
    #1;
    check_val("lbu_bypass", r1_dout, 32'h000000FF);
    tick();
    idle();
    #1;
    check_val("lbu_stored", r1_dout, 32'h000000FF);
    check_val("load_no_commit_r9", r2_dout, 32'h0);
    @(negedge clk);

    // r0 protection
    drive_wb(1'b1, 1'b0, 32'hFFFFFFFF, 5'd0, 6'h0, 32'h0);
    set_reads(5'd0, 5'd0);
    #1;
    check_val("r0_wbdata", wb_dataW, 32'hFFFFFFFF);
    check_val("r0_bypass_r1", r1_dout, 32'h0);
    check_val("r0_bypass_r2", r2_dout, 32'h0);
    tick();
    idle();
    #1;
    check_val("r0_stored_r1", r1_dout, 32'h0);
    check_val("r0_count", wb_count, model_count);
    check_val("r0_count_abs", wb_count, 32'd3);
    @(negedge clk);

    // Dual port
    write_reg(5'd10, 32'hA);
    write_reg(5'd11, 32'hB);
    set_reads(5'd10, 5'd11);
    #1;
    check_val("dual_r1", r1_dout, 32'hA);
    check_val("dual_r2", r2_dout, 32'hB);
    set_reads(5'd10, 5'd10);
    #1;
    check_val("same_r1", r1_dout, 32'hA);
    check_val("same_r2", r2_dout, 32'hA);
    @(negedge clk);
    drive_wb(1'b1, 1'b0, 32'hC, 5'd11, 6'h0, 32'h0);
    set_reads(5'd10, 5'd11);
    #1;
    check_val("bypass_r2_only_r1", r1_dout, 32'hA);
    check_val("bypass_r2_only_r2", r2_dout, 32'hC);
    tick();
    idle();
    #1;
    check_val("dual_count", wb_count, model_count);
    @(negedge clk);

    // Reset mid-operation
    write_reg(5'd5, 32'h1234);
    set_reads(5'd5, 5'd6);
    #1;
    check_val("pre_reset_r5", r1_dout, 32'h1234);
    rst_n = 1'b0;
    #1;
    check_val("reset_now_r5", r1_dout, 32'h0);
    check_val("reset_now_count", wb_count, 32'h0);
    model_count = 32'h0;
    @(negedge clk);
    drive_wb(1'b1, 1'b0, 32'h6666, 5'd6, 6'h0, 32'h0);
    tick();
    idle();
    rst_n = 1'b1;
    #1;
    check_val("after_reset_r5", r1_dout, 32'h0);
    check_val("lost_write_r6", r2_dout, 32'h0);
    check_val("after_reset_count", wb_count, 32'h0);
    @(negedge clk);

    // Counter wrap via deposit
    dut.wbCount = 32'hFFFFFFFF;
    model_count = 32'hFFFFFFFF;
    tick();
    #1;
    check_val("count_hold", wb_count, 32'hFFFFFFFF);
    @(negedge clk);
    drive_wb(1'b1, 1'b0, 32'h1, 5'd1, 6'h0, 32'h0);
    tick();
    idle();
    #1;
    check_val("count_wrap", wb_count, 32'h0);
    check_val("count_wrap_model", wb_count, model_count);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
